// File: rtl/jump_pkg.sv
// Shared constants and types for the jump redirect unit.
//   OP_J / OP_JAL / OP_SPECIAL : primary opcodes decoded in ID
//   FUNCT_JR                   : R-type funct code of JR
//   redirect_src_e             : which source wins the fetch redirect
//   clog2                      : elaboration-time ceil(log2)
package jump_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_EX_JR,
        RD_ID_J,
        RD_ID_JR
    } redirect_src_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/jump_redirect_unit_if.sv
// Pipeline-side bundle of the jump redirect unit.
//   ID/EX inputs : stall, id_valid, id_instr, id_pc_plus1,
//                  ex_valid, ex_rtype, ex_funct, ex_rs_val
//   outputs      : redirect_valid, redirect_target, flush_mask,
//                  jr_mispredict, ras_count
// master = pipeline side, slave = jump_redirect_unit.
interface jump_redirect_unit_if #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned RAS_DEPTH    = 8,
    parameter int unsigned FLUSH_STAGES = 2
);
    import jump_pkg::*;

    localparam int unsigned CNT_W = clog2(RAS_DEPTH) + 1;

    logic                    stall;
    logic                    id_valid;
    logic [31:0]             id_instr;
    logic [ADDR_W-1:0]       id_pc_plus1;
    logic                    ex_valid;
    logic                    ex_rtype;
    logic [5:0]              ex_funct;
    logic [ADDR_W-1:0]       ex_rs_val;
    logic                    redirect_valid;
    logic [ADDR_W-1:0]       redirect_target;
    logic [FLUSH_STAGES-1:0] flush_mask;
    logic                    jr_mispredict;
    logic [CNT_W-1:0]        ras_count;

    modport master (
        output stall, id_valid, id_instr, id_pc_plus1,
               ex_valid, ex_rtype, ex_funct, ex_rs_val,
        input  redirect_valid, redirect_target, flush_mask,
               jr_mispredict, ras_count
    );

    modport slave (
        input  stall, id_valid, id_instr, id_pc_plus1,
               ex_valid, ex_rtype, ex_funct, ex_rs_val,
        output redirect_valid, redirect_target, flush_mask,
               jr_mispredict, ras_count
    );

endinterface

// File: rtl/jump_redirect_unit_ras_stack.sv
// ras_stack: circular return-address LIFO.
//   push/push_addr : store a return address (overwrites oldest when full)
//   pop            : drop the top entry (caller guarantees count > 0)
//   top            : current top entry
//   count          : valid entries, saturates at RAS_DEPTH
module ras_stack
    import jump_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [ADDR_W-1:0]           push_addr,
    output logic [ADDR_W-1:0]           top,
    output logic [clog2(RAS_DEPTH):0]   count
);
    localparam int unsigned PTR_W = clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;   // next free slot; top lives at ptr-1

    // Power-of-two depth lets the pointer wrap naturally, so a push on a
    // full stack lands on the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_ONE;
            if (count != FULL) count <= count + CNT_ONE;
        end else if (pop && count != '0) begin
            ptr   <= ptr - PTR_ONE;
            count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= push_addr;
    end

    assign top = mem[ptr - PTR_ONE];

endmodule

// File: rtl/jump_redirect_unit.sv
// jump_redirect_unit: decodes J/JAL/JR in ID, predicts JR from a RAS,
// verifies JR in EX and drives a registered fetch redirect.
//   clk, rst : pipeline clock, async active-high reset
//   bus      : jump_redirect_unit_if.slave (ID/EX inputs, redirect outputs)
module jump_redirect_unit
    import jump_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned RAS_DEPTH    = 8,
    parameter int unsigned FLUSH_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    jump_redirect_unit_if.slave  bus
);
    localparam int unsigned CNT_W = clog2(RAS_DEPTH) + 1;

    logic [5:0]              id_op;
    logic [5:0]              id_funct;
    logic                    id_is_j;
    logic                    id_is_jal;
    logic                    id_is_jr;
    logic                    id_flushed;
    logic                    id_ok;
    logic                    ex_is_jr;
    logic                    ex_mispredict;
    logic                    ras_push;
    logic                    ras_pop;
    logic [ADDR_W-1:0]       ras_top;
    logic [CNT_W-1:0]        ras_cnt;
    logic [ADDR_W-1:0]       jump_target;
    logic [FLUSH_STAGES:0]   flush_ext;
    redirect_src_e           src;

    logic                    rv_q, rv_d;
    logic [ADDR_W-1:0]       tgt_q, tgt_d;
    logic [FLUSH_STAGES-1:0] fm_q, fm_d;
    logic                    mis_q, mis_d;
    logic                    trk_valid_q;
    logic [ADDR_W-1:0]       trk_target_q;

    assign id_op     = bus.id_instr[31:26];
    assign id_funct  = bus.id_instr[5:0];
    assign id_is_j   = (id_op == OP_J);
    assign id_is_jal = (id_op == OP_JAL);
    assign id_is_jr  = (id_op == OP_SPECIAL) && (id_funct == FUNCT_JR);
    assign jump_target = ADDR_W'(bus.id_instr[25:0]);

    // Extended by one bit so the ID-flush test stays legal for FLUSH_STAGES == 1.
    assign flush_ext  = {1'b0, fm_q};
    assign id_flushed = rv_q & flush_ext[1];

    // EX verification only advances with the pipeline, so a stalled JR
    // raises its corrective redirect once.
    assign ex_is_jr = ~bus.stall & bus.ex_valid & bus.ex_rtype &
                      (bus.ex_funct == FUNCT_JR);
    assign ex_mispredict = ex_is_jr &
                           (~trk_valid_q | (trk_target_q != bus.ex_rs_val));

    assign id_ok    = ~bus.stall & bus.id_valid & ~ex_mispredict & ~id_flushed;
    assign ras_push = id_ok & id_is_jal;
    assign ras_pop  = id_ok & id_is_jr & (ras_cnt != '0);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (bus.id_pc_plus1),
        .top       (ras_top),
        .count     (ras_cnt)
    );

    always_comb begin
        src   = RD_NONE;
        rv_d  = 1'b0;
        tgt_d = '0;
        fm_d  = '0;
        mis_d = 1'b0;
        if (ex_mispredict)                    src = RD_EX_JR;
        else if (id_ok & (id_is_j | id_is_jal)) src = RD_ID_J;
        else if (ras_pop)                     src = RD_ID_JR;
        case (src)
            RD_EX_JR: begin
                rv_d  = 1'b1;
                tgt_d = bus.ex_rs_val;
                fm_d  = '1;
                mis_d = 1'b1;
            end
            RD_ID_J: begin
                rv_d  = 1'b1;
                tgt_d = jump_target;
                fm_d  = FLUSH_STAGES'(1);
            end
            RD_ID_JR: begin
                rv_d  = 1'b1;
                tgt_d = ras_top;
                fm_d  = FLUSH_STAGES'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q         <= 1'b0;
            tgt_q        <= '0;
            fm_q         <= '0;
            mis_q        <= 1'b0;
            trk_valid_q  <= 1'b0;
            trk_target_q <= '0;
        end else begin
            rv_q  <= rv_d;
            tgt_q <= tgt_d;
            fm_q  <= fm_d;
            mis_q <= mis_d;
            // ras_pop already excludes gated/flushed ID slots, so a wrong-path
            // JR is captured as an invalid prediction.
            if (!bus.stall) begin
                trk_valid_q  <= ras_pop;
                trk_target_q <= ras_pop ? ras_top : '0;
            end
        end
    end

    assign bus.redirect_valid  = rv_q;
    assign bus.redirect_target = tgt_q;
    assign bus.flush_mask      = fm_q;
    assign bus.jr_mispredict   = mis_q;
    assign bus.ras_count       = ras_cnt;

endmodule
